// File: rtl/dtcm_lsu.sv
// Load/store unit for a single-port-per-direction data TCM without byte enables.
// Sub-word loads are lane-extracted and extended; sub-word stores use read-modify-write.
module dtcm_lsu #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic          REQ_WE,
  input  logic [AW+1:0] REQ_ADDR,
  input  logic [1:0]    REQ_SIZE,
  input  logic          REQ_UNSIGNED,
  input  logic [DW-1:0] REQ_WDATA,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [DW-1:0] RSP_RDATA,
  output logic          RSP_ERR,
  output logic [AW-1:0] WADDR,
  output logic [DW-1:0] WDATA,
  output logic          WEN,
  output logic [AW-1:0] RADDR,
  output logic          REN,
  input  logic [DW-1:0] RDATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW,
    S_WRITE,
    S_RESP
  } state_t;

  state_t        r_state;
  logic [AW+1:0] r_addr;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [DW-1:0] r_merge;
  logic [DW-1:0] r_rdata;
  logic          r_err;

  logic          w_live;
  logic          w_err;
  logic          w_go_load;
  logic          w_go_write;
  logic          w_go_rmw;
  logic [4:0]    w_lane;
  logic [DW-1:0] w_shift;
  logic [DW-1:0] w_load;
  logic [DW-1:0] w_merge;

  assign w_live = !RST;

  assign w_err = (REQ_SIZE == 2'd3)
               | ((REQ_SIZE == 2'd1) & REQ_ADDR[0])
               | ((REQ_SIZE == 2'd2) & (|REQ_ADDR[1:0]));

  assign w_go_load  = !w_err && !REQ_WE;
  assign w_go_write = !w_err && REQ_WE
                   && (REQ_SIZE == 2'd2);
  assign w_go_rmw   = !w_err && REQ_WE
                   && (REQ_SIZE != 2'd2);

  // Half accesses are aligned, so the byte-lane shift also selects the half lane.
  assign w_lane  = {r_addr[1:0], 3'b000};
  assign w_shift = RDATA >> w_lane;

  always_comb begin
    w_load = RDATA;
    unique case (r_size)
      2'd0: w_load = r_uns
        ? {24'h0, w_shift[7:0]}
        : {{24{w_shift[7]}}, w_shift[7:0]};
      2'd1: w_load = r_uns
        ? {16'h0, w_shift[15:0]}
        : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_load = RDATA;
    endcase
  end

  // r_merge still holds the right-aligned store data while in RMW.
  always_comb begin
    w_merge = RDATA;
    unique case (r_size)
      2'd0: w_merge[w_lane +: 8] = r_merge[7:0];
      2'd1: w_merge[{r_addr[1], 4'b0000} +: 16] =
              r_merge[15:0];
      default: w_merge = r_merge;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_merge <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (REQ_VALID) begin
            r_addr  <= REQ_ADDR;
            r_size  <= REQ_SIZE;
            r_uns   <= REQ_UNSIGNED;
            r_merge <= REQ_WDATA;
            r_rdata <= '0;
            r_err   <= w_err;
            unique case (1'b1)
              w_err:      r_state <= S_RESP;
              w_go_load:  r_state <= S_LOAD;
              w_go_write: r_state <= S_WRITE;
              w_go_rmw:   r_state <= S_RMW;
            endcase
          end
        end
        S_LOAD: begin
          r_rdata <= w_load;
          r_state <= S_RESP;
        end
        S_RMW: begin
          r_merge <= w_merge;
          r_state <= S_WRITE;
        end
        S_WRITE: r_state <= S_RESP;
        S_RESP: begin
          if (RSP_READY) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are gated by reset so nothing reaches memory on a reset edge.
  assign REQ_READY = w_live && (r_state == S_IDLE);
  assign RSP_VALID = w_live && (r_state == S_RESP);
  assign REN = w_live
            && ((r_state == S_LOAD)
             || (r_state == S_RMW));
  assign WEN = w_live && (r_state == S_WRITE);

  assign RADDR = REN ? r_addr[AW+1:2] : '0;
  assign WADDR = WEN ? r_addr[AW+1:2] : '0;
  assign WDATA = WEN ? r_merge : '0;

  assign RSP_RDATA = r_rdata;
  assign RSP_ERR   = r_err;

endmodule

// File: tb/tb_dtcm_lsu.sv
// Bench for dtcm_lsu: directed vector table, reset-mid-RMW sequence,
// and random traffic checked against a byte-array memory model.
module tb_dtcm_lsu;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [5:0]  REQ_ADDR;
  logic [1:0]  REQ_SIZE;
  logic        REQ_UNSIGNED;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [3:0]  WADDR;
  logic [31:0] WDATA;
  logic        WEN;
  logic [3:0]  RADDR;
  logic        REN;
  logic [31:0] RDATA;

  dtcm_lsu #(.AW(4), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED),
    .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .WADDR(WADDR), .WDATA(WDATA), .WEN(WEN),
    .RADDR(RADDR), .REN(REN), .RDATA(RDATA)
  );

  always #5 CLK = ~CLK;

  // Memory attached to the DUT port
  logic [31:0] mem [16];
  logic        init_mem = 1'b1;
  int          wen_n = 0;
  int          ren_n = 0;
  logic [3:0]  last_waddr;
  logic [31:0] last_wdata;

  assign RDATA = REN ? mem[RADDR] : 32'hBAD0_BAD0;

  always @(posedge CLK) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (WEN) begin
      mem[WADDR] <= WDATA;
    end
  end

  always @(posedge CLK) begin
    if (WEN) begin
      wen_n++;
      last_waddr = WADDR;
      last_wdata = WDATA;
    end
    if (REN) ren_n++;
  end

  // Reference model: byte-addressed little-endian memory
  logic [7:0] sh [64];

  function automatic logic ref_err(input logic [5:0] a,
                                   input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a[0])
        || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] a,
                                           input logic [1:0] sz,
                                           input logic uns);
    longint unsigned v = 0;
    int n = 1 << sz;
    for (int i = 0; i < n; i++)
      v |= longint'(sh[a + i]) << (8 * i);
    if (!uns && v[8*n-1]) v |= (~64'h0) << (8 * n);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [5:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
    int n = 1 << sz;
    for (int i = 0; i < n; i++) sh[a + i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] sh_word(input int w);
    return {sh[4*w+3], sh[4*w+2], sh[4*w+1], sh[4*w]};
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [5:0]  a;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          hold;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [5:0] a,
                              input logic [1:0] sz, input logic uns,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input logic err, input int lat,
                              input int hold);
    vec_t v;
    v.we = we; v.a = a; v.sz = sz; v.uns = uns; v.wd = wd;
    v.rd = rd; v.err = err; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  task automatic run(input vec_t v, input string nm);
    int n, w0, r0, lat;
    logic [31:0] rd0;
    logic err0;
    logic exp_wen, exp_ren;
    exp_wen = v.we && !v.err;
    exp_ren = !v.err && !(v.we && v.sz == 2'd2);
    @(negedge CLK);
    REQ_WE = v.we; REQ_ADDR = v.a; REQ_SIZE = v.sz;
    REQ_UNSIGNED = v.uns; REQ_WDATA = v.wd; REQ_VALID = 1'b1;
    n = 0;
    while (!REQ_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!REQ_READY) begin
      chk({nm, ".ready_timeout"}, 0, 1);
      REQ_VALID = 1'b0;
      return;
    end
    w0 = wen_n;
    r0 = ren_n;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    REQ_WDATA = $urandom;
    lat = 1;
    while (!RSP_VALID && lat < 10) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    chk({nm, ".latency"}, lat, v.lat);
    if (!RSP_VALID) begin
      chk({nm, ".rsp_timeout"}, 0, 1);
      return;
    end
    chk({nm, ".rdata"}, RSP_RDATA, v.rd);
    chk({nm, ".err"}, RSP_ERR, v.err);
    rd0 = RSP_RDATA;
    err0 = RSP_ERR;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge CLK);
      #1;
      chk({nm, ".hold_stable"},
          {RSP_VALID, REQ_READY, RSP_ERR, RSP_RDATA},
          {1'b1, 1'b0, err0, rd0});
    end
    @(negedge CLK);
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1;
    RSP_READY = 1'b0;
    chk({nm, ".idle_after"}, {REQ_READY, RSP_VALID}, 2'b10);
    chk({nm, ".wen_count"}, wen_n - w0, exp_wen ? 1 : 0);
    chk({nm, ".ren_count"}, ren_n - r0, exp_ren ? 1 : 0);
    if (exp_wen) begin
      ref_store(v.a, v.sz, v.wd);
      chk({nm, ".waddr"}, last_waddr, v.a[5:2]);
      chk({nm, ".wdata"}, last_wdata, sh_word(int'(v.a[5:2])));
    end
  endtask

  vec_t tv[$];
  vec_t rv;
  int   w0;

  initial begin
    RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0;
    REQ_SIZE = '0; REQ_UNSIGNED = 1'b0; REQ_WDATA = '0;
    RSP_READY = 1'b0;
    for (int i = 0; i < 64; i++) sh[i] = 8'h00;

    tv.push_back(mk(1, 6'h08, 2, 0, 32'hDEADBEEF, 0, 0, 2, 0));
    tv.push_back(mk(0, 6'h08, 2, 0, 0, 32'hDEADBEEF, 0, 2, 0));
    tv.push_back(mk(1, 6'h08, 2, 0, 32'h11223344, 0, 0, 2, 0));
    tv.push_back(mk(1, 6'h09, 0, 0, 32'h000000AA, 0, 0, 3, 0));
    tv.push_back(mk(0, 6'h08, 2, 0, 0, 32'h1122AA44, 0, 2, 0));
    tv.push_back(mk(1, 6'h0C, 2, 0, 32'h80F07F01, 0, 0, 2, 0));
    tv.push_back(mk(0, 6'h0E, 0, 0, 0, 32'hFFFFFFF0, 0, 2, 0));
    tv.push_back(mk(0, 6'h0E, 0, 1, 0, 32'h000000F0, 0, 2, 0));
    tv.push_back(mk(0, 6'h0E, 1, 0, 0, 32'hFFFF80F0, 0, 2, 0));
    tv.push_back(mk(0, 6'h0C, 1, 1, 0, 32'h00007F01, 0, 2, 0));
    tv.push_back(mk(0, 6'h0A, 2, 0, 0, 0, 1, 1, 0));
    tv.push_back(mk(1, 6'h05, 1, 0, 32'h00005555, 0, 1, 1, 0));
    tv.push_back(mk(0, 6'h04, 2, 0, 0, 0, 0, 2, 0));
    tv.push_back(mk(0, 6'h00, 3, 0, 0, 0, 1, 1, 0));
    tv.push_back(mk(1, 6'h3C, 2, 0, 32'hA5B6C7D8, 0, 0, 2, 0));
    tv.push_back(mk(0, 6'h3F, 0, 0, 0, 32'hFFFFFFA5, 0, 2, 0));
    tv.push_back(mk(1, 6'h3E, 1, 0, 32'hFFFF1234, 0, 0, 3, 0));
    tv.push_back(mk(0, 6'h3C, 2, 0, 0, 32'h1234C7D8, 0, 2, 0));
    tv.push_back(mk(0, 6'h08, 2, 0, 0, 32'h1122AA44, 0, 2, 5));

    repeat (2) @(posedge CLK);
    #1;
    chk("reset.ctrl", {REQ_READY, RSP_VALID, RSP_ERR, WEN, REN}, 5'b0);
    chk("reset.data", {RSP_RDATA, WDATA}, 64'h0);
    chk("reset.addr", {WADDR, RADDR}, 8'h0);
    @(negedge CLK);
    RST = 1'b0;
    init_mem = 1'b0;
    #1;
    chk("reset.ready_after", REQ_READY, 1'b1);

    foreach (tv[i]) run(tv[i], $sformatf("vec%0d", i));

    // Reset arriving during the read half of a byte RMW
    run(mk(1, 6'h04, 2, 0, 32'hCAFEF00D, 0, 0, 2, 0), "rmw_rst.pre");
    @(negedge CLK);
    REQ_WE = 1'b1; REQ_ADDR = 6'h05; REQ_SIZE = 2'd0;
    REQ_WDATA = 32'h77; REQ_VALID = 1'b1;
    w0 = wen_n;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    chk("rmw_rst.in_rmw", {REN, RADDR}, {1'b1, 4'd1});
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("rmw_rst.ctrl", {REQ_READY, RSP_VALID, RSP_ERR, WEN, REN}, 5'b0);
    chk("rmw_rst.data", {RSP_RDATA, WDATA}, 64'h0);
    chk("rmw_rst.addr", {WADDR, RADDR}, 8'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("rmw_rst.no_wen", wen_n - w0, 0);
    chk("rmw_rst.mem", mem[1], 32'hCAFEF00D);
    chk("rmw_rst.ready", REQ_READY, 1'b1);
    run(mk(0, 6'h04, 2, 0, 0, 32'hCAFEF00D, 0, 2, 0), "rmw_rst.load");

    for (int i = 0; i < 80; i++) begin
      rv.we = 1'($urandom_range(0, 1));
      rv.a = 6'($urandom_range(0, 63));
      rv.sz = 2'($urandom_range(0, 3));
      if (rv.sz != 2'd3 && $urandom_range(0, 3) != 0)
        rv.a = rv.a & ~6'((1 << rv.sz) - 1);
      rv.uns = 1'($urandom_range(0, 1));
      rv.wd = $urandom;
      rv.err = ref_err(rv.a, rv.sz);
      rv.rd = (rv.err || rv.we) ? 32'h0 : ref_load(rv.a, rv.sz, rv.uns);
      rv.lat = rv.err ? 1 : (rv.we && rv.sz != 2'd2) ? 3 : 2;
      rv.hold = $urandom_range(0, 2);
      run(rv, $sformatf("rnd%0d", i));
    end

    for (int w = 0; w < 16; w++)
      chk($sformatf("final.mem%0d", w), mem[w], sh_word(w));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
